mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF, read-only) and the data requester (MEM stage, read/write).
- Serialises accesses and returns read data with a one-cycle ready pulse.
- Supplies the stall signals the pipeline uses to freeze IF and MEM while an access is pending.
- Sits between the IF/MEM stages and the memory macro.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- LATENCY, 4, cycles mem_en is held per access (≥1).
- MAX_D_BURST, 4, consecutive data grants allowed while an instruction request waits (≥1).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction read request; held until i_rdy.
- i_addr  in  ADDR_W  instruction address; stable while i_req.
- i_flush  in  1  pulse; discard the in-flight/pending fetch (taken branch).
- hlt  in  1  processor halted; no new instruction grants.
- i_rdy  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DATA_W  fetched instruction.
- i_stall  out  1  i_req & ~i_rdy.
- d_req  in  1  data request; held until d_rdy.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdy  out  1  one-cycle pulse; access complete, d_rdata valid for reads.
- d_rdata  out  DATA_W  read data.
- d_stall  out  1  d_req & ~d_rdy.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last mem_en cycle.

Behaviour:
- Reset (async, any time):
  - State IDLE; cnt, burst counter and kill flag 0.
  - All outputs 0, including i_rdata and d_rdata.
  - A write interrupted by reset leaves memory contents undefined at that address.
- States: IDLE, BUSY, RESP. Owner register `own` (0 = instr, 1 = data).
- IDLE arbitration, decided on the edge:
  - d_req and (burst < MAX_D_BURST or ~i_req or hlt) -> grant data.
  - else i_req & ~hlt & ~i_flush -> grant instr.
  - else d_req -> grant data.
  - else stay.
- On grant:
  - Latch owner, addr, we (0 for instr) and wdata.
  - Go to BUSY with cnt = 1.
- BUSY:
  - mem_en = 1 and mem_addr/mem_we/mem_wdata come from the latched values, all stable for exactly LATENCY cycles.
  - cnt increments each cycle.
  - When cnt == LATENCY: capture mem_rdata into the owner's rdata register (data reads only for d_rdata; d_rdata keeps its old value on writes), then go to RESP.
- RESP:
  - mem_en = 0.
  - Pulse the owner's rdy for this one cycle; the kill rule below can suppress i_rdy.
  - Next state IDLE. Requests are not sampled in RESP.
- Latency: grant edge to rdy is LATENCY+1 cycles. The earliest next grant is the cycle after RESP, so there is at least 1 idle cycle between accesses.
- Burst counter:
  - Increments on each data grant while i_req is high, saturating at MAX_D_BURST.
  - Clears on an instruction grant, or whenever i_req is low in IDLE.
- i_flush:
  - In BUSY or RESP with own = instr: set kill. A RESP with kill suppresses i_rdy and does not update i_rdata. kill clears on leaving RESP.
  - The memory access itself is never aborted.
  - In IDLE: blocks an instruction grant that cycle.
  - i_flush has no effect on data accesses.
- hlt: blocks new instruction grants only. An in-flight fetch completes normally. Data accesses are unaffected.
- Simultaneous d_req and i_req in IDLE: data wins unless the burst limit is reached.
- A requester deasserting req mid-access is illegal. The access still completes and rdy still pulses.
- i_stall and d_stall are combinational from req and rdy.

Test Plan:
- LATENCY=4. i_req, i_addr=0x0010, memory returns 0xA5A5 -> mem_en high 4 cycles at addr 0x0010. i_rdy pulses once, 5 cycles after grant, with i_rdata=0xA5A5. i_stall is high until then.
- d_req write: addr 0x0020, wdata 0x1234 -> mem_we=1 for 4 cycles, then d_rdy pulse; d_rdata unchanged. Follow-up read of 0x0020 returns d_rdata=0x1234.
- i_req and d_req both asserted in the same IDLE cycle -> data is served first. The instruction is granted on the first IDLE cycle after d_rdy.
- MAX_D_BURST=2, continuous d_req and i_req -> grant order D, D, I, D, D, I. No instruction starvation.
- i_flush pulses in the 2nd BUSY cycle of a fetch -> mem_en still lasts 4 cycles. No i_rdy, and i_rdata is unchanged.
- rst asserted in the 3rd BUSY cycle -> mem_en and all outputs drop to 0 immediately. After release the state is IDLE, and a new d_req completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the IF/MEM requesters and the memory macro to the arbiter.
// The arbiter uses the slave view; the surrounding pipeline and memory use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              hlt;
    logic              i_rdy;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rdy;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_flush, hlt, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdy, i_rdata, i_stall, d_rdy, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_flush, hlt, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdy, i_rdata, i_stall, d_rdy, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one fixed-latency memory,
// returning read data with a one-cycle ready pulse per requester.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LATENCY     = 4,
    parameter int MAX_D_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W   = $clog2(LATENCY + 1);
    localparam int BURST_W = $clog2(MAX_D_BURST + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(LATENCY);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BURST_W-1:0] burst_r;
    logic               kill_r;
    logic               own_r;
    logic               mem_en_r;
    logic               mem_we_r;
    logic               i_rdy_r;
    logic               d_rdy_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [DATA_W-1:0]  i_rdata_r;
    logic [DATA_W-1:0]  d_rdata_r;

    logic grant_d_s;
    logic grant_i_s;
    logic last_s;
    logic kill_now_s;

    // IDLE arbitration: data first unless a waiting fetch has hit the burst limit
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.d_req && ((burst_r < BURST_MAX) || !bus.i_req || bus.hlt)) begin
                grant_d_s = 1'b1;
            end else if (bus.i_req && !bus.hlt && !bus.i_flush) begin
                grant_i_s = 1'b1;
            end else if (bus.d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    assign last_s     = (state_r == ST_BUSY) && (cnt_r == CNT_LAST);
    // A flush arriving in the final busy cycle must still suppress this fetch's result
    assign kill_now_s = kill_r | (bus.i_flush & ~own_r);

    // Access sequencer: grant latch, latency count, result capture and ready pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            own_r     <= 1'b0;
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            i_rdy_r   <= 1'b0;
            d_rdy_r   <= 1'b0;
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s || grant_i_s) begin
                        state_r  <= ST_BUSY;
                        cnt_r    <= CNT_ONE;
                        own_r    <= grant_d_s;
                        mem_en_r <= 1'b1;
                        mem_we_r <= grant_d_s & bus.d_we;
                        addr_r   <= grant_d_s ? bus.d_addr : bus.i_addr;
                        wdata_r  <= grant_d_s ? bus.d_wdata : {DATA_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_s) begin
                        state_r  <= ST_RESP;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        if (own_r) begin
                            d_rdy_r <= 1'b1;
                            if (!mem_we_r) begin
                                d_rdata_r <= bus.mem_rdata;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end else if (!kill_now_s) begin
                            i_rdy_r   <= 1'b1;
                            i_rdata_r <= bus.mem_rdata;
                        end else begin
                            i_rdy_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    i_rdy_r <= 1'b0;
                    d_rdy_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    i_rdy_r  <= 1'b0;
                    d_rdy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Kill flag: remembers a flush hitting an instruction access until its response slot ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_r <= 1'b0;
        end else if (state_r == ST_RESP) begin
            kill_r <= 1'b0;
        end else if ((state_r == ST_BUSY) && !own_r && bus.i_flush) begin
            kill_r <= 1'b1;
        end else begin
            kill_r <= kill_r;
        end
    end

    // Burst counter: consecutive data grants made while a fetch is waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (!bus.i_req || grant_i_s) begin
                burst_r <= {BURST_W{1'b0}};
            end else if (grant_d_s && (burst_r < BURST_MAX)) begin
                burst_r <= burst_r + BURST_ONE;
            end else begin
                burst_r <= burst_r;
            end
        end else begin
            burst_r <= burst_r;
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.i_rdy     = i_rdy_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdy     = d_rdy_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.i_stall   = bus.i_req & ~i_rdy_r;
    assign bus.d_stall   = bus.d_req & ~d_rdy_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected read data is queued when a request is
// issued and popped when the matching ready pulse appears.
module tb_mem_arbiter;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int LATENCY     = 4;
    localparam int MAX_D_BURST = 2;

    logic clk;
    logic rst;
    logic init_mem;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MAX_D_BURST(MAX_D_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    int unstable = 0;
    logic        prev_en = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] prev_wdata = 16'h0000;
    logic        prev_we = 1'b0;

    logic [15:0] mem [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_i_q [$];
    logic [15:0] exp_d_q [$];
    logic [15:0] start_addr_q [$];
    int          start_cyc_q [$];
    logic [15:0] last_i_rdata = 16'h0000;
    logic [15:0] last_d_rdata = 16'h0000;

    function automatic logic [15:0] pat(input int k);
        logic [7:0] b;
        b = k[7:0];
        return (k == 16) ? 16'hA5A5 : {b ^ 8'h3C, b};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= pat(k);
        end else if (!rst && bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en) en_cnt <= en_cnt + 1;
        if (bus.mem_en && bus.mem_we) we_cnt <= we_cnt + 1;
        if (bus.mem_en && !prev_en) begin
            start_addr_q.push_back(bus.mem_addr);
            start_cyc_q.push_back(cyc);
        end
        if (bus.mem_en && prev_en &&
            (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we || bus.mem_wdata !== prev_wdata))
            unstable <= unstable + 1;
        prev_en    <= bus.mem_en;
        prev_addr  <= bus.mem_addr;
        prev_we    <= bus.mem_we;
        prev_wdata <= bus.mem_wdata;
    end

    task automatic fetch(input logic [15:0] addr, output int req_cyc, output int rdy_cyc);
        logic [15:0] exp_v;
        bit seen;
        seen = 1'b0;
        req_cyc = -1;
        rdy_cyc = -1;
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        exp_i_q.push_back(ref_mem[addr[7:0]]);
        last_i_rdata = ref_mem[addr[7:0]];
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) begin
                req_cyc = cyc;
                checks++;
                if (bus.i_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL i_stall_wait: got %b expected 1", bus.i_stall);
                end
            end
            if (bus.i_rdy) begin
                seen = 1'b1;
                rdy_cyc = cyc;
                exp_v = exp_i_q.pop_front();
                checks++;
                if (bus.i_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL i_rdata @%h: got %h expected %h", addr, bus.i_rdata, exp_v);
                end
                checks++;
                if (bus.i_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL i_stall_rdy: got %b expected 0", bus.i_stall);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL i_rdy_timeout @%h: no ready pulse", addr);
            if (exp_i_q.size() > 0) void'(exp_i_q.pop_back());
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output int req_cyc, output int rdy_cyc);
        logic [15:0] exp_v;
        bit seen;
        seen = 1'b0;
        req_cyc = -1;
        rdy_cyc = -1;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        if (we) begin
            ref_mem[addr[7:0]] = wdata;
            exp_d_q.push_back(last_d_rdata);
        end else begin
            exp_d_q.push_back(ref_mem[addr[7:0]]);
            last_d_rdata = ref_mem[addr[7:0]];
        end
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) begin
                req_cyc = cyc;
                checks++;
                if (bus.d_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL d_stall_wait: got %b expected 1", bus.d_stall);
                end
            end
            if (bus.d_rdy) begin
                seen = 1'b1;
                rdy_cyc = cyc;
                exp_v = exp_d_q.pop_front();
                checks++;
                if (bus.d_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL d_rdata @%h we=%b: got %h expected %h", addr, we, bus.d_rdata, exp_v);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL d_rdy_timeout @%h: no ready pulse", addr);
            if (exp_d_q.size() > 0) void'(exp_d_q.pop_back());
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        rst = 1'b1;
        init_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {bus.i_rdy, bus.d_rdy, bus.i_stall, bus.d_stall, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata};
        checks++;
        if (obs !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        init_mem = 1'b0;
    endtask

    task automatic test_instr_fetch();
        int rq, rd, en0, ns;
        en0 = en_cnt;
        ns = start_addr_q.size();
        fetch(16'h0010, rq, rd);
        checks++;
        if (rd - rq !== LATENCY + 1) begin
            errors++;
            $display("FAIL fetch_latency: got %0d expected %0d", rd - rq, LATENCY + 1);
        end
        checks++;
        if (en_cnt - en0 !== LATENCY) begin
            errors++;
            $display("FAIL fetch_mem_en_len: got %0d expected %0d", en_cnt - en0, LATENCY);
        end
        checks++;
        if (start_addr_q.size() !== ns + 1 || start_addr_q[ns] !== 16'h0010) begin
            errors++;
            $display("FAIL fetch_mem_addr: got %0d accesses expected 1 at 0010", start_addr_q.size() - ns);
        end
        @(negedge clk);
        checks++;
        if (bus.i_rdy !== 1'b0 || bus.i_rdata !== 16'hA5A5) begin
            errors++;
            $display("FAIL fetch_pulse: got rdy=%b rdata=%h expected rdy=0 rdata=a5a5", bus.i_rdy, bus.i_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_data_write_read();
        int rq, rd, we0;
        data_req(1'b0, 16'h0021, 16'h0000, rq, rd);
        we0 = we_cnt;
        data_req(1'b1, 16'h0020, 16'h1234, rq, rd);
        checks++;
        if (we_cnt - we0 !== LATENCY) begin
            errors++;
            $display("FAIL write_mem_we_len: got %0d expected %0d", we_cnt - we0, LATENCY);
        end
        checks++;
        if (rd - rq !== LATENCY + 1) begin
            errors++;
            $display("FAIL write_latency: got %0d expected %0d", rd - rq, LATENCY + 1);
        end
        data_req(1'b0, 16'h0020, 16'h0000, rq, rd);
    endtask

    task automatic test_simultaneous();
        int rqi, rdi, rqd, rdd, ns;
        ns = start_addr_q.size();
        fork
            fetch(16'h0030, rqi, rdi);
            data_req(1'b0, 16'h0040, 16'h0000, rqd, rdd);
        join
        checks++;
        if (start_addr_q.size() !== ns + 2 || start_addr_q[ns] !== 16'h0040 ||
            start_addr_q[ns + 1] !== 16'h0030) begin
            errors++;
            $display("FAIL simul_order: got %0d accesses, expected data 0040 then instr 0030",
                     start_addr_q.size() - ns);
        end else begin
            checks++;
            if (start_cyc_q[ns + 1] !== rdd + 2) begin
                errors++;
                $display("FAIL simul_instr_grant: got cycle %0d expected %0d", start_cyc_q[ns + 1], rdd + 2);
            end
        end
    endtask

    task automatic test_burst_fairness();
        logic [15:0] exp_ord [6];
        int ns;
        exp_ord = '{16'h0050, 16'h0051, 16'h0060, 16'h0052, 16'h0053, 16'h0061};
        ns = start_addr_q.size();
        fork
            begin
                int rq, rd;
                for (int t = 0; t < 4; t++) data_req(1'b0, 16'(16'h0050 + t), 16'h0000, rq, rd);
            end
            begin
                int rq, rd;
                for (int t = 0; t < 2; t++) fetch(16'(16'h0060 + t), rq, rd);
            end
        join
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (start_addr_q.size() <= ns + k) begin
                errors++;
                $display("FAIL burst_order[%0d]: missing access expected %h", k, exp_ord[k]);
            end else if (start_addr_q[ns + k] !== exp_ord[k]) begin
                errors++;
                $display("FAIL burst_order[%0d]: got %h expected %h", k, start_addr_q[ns + k], exp_ord[k]);
            end
        end
    endtask

    task automatic test_flush();
        logic [15:0] keep_v;
        int en0, rdy_seen;
        bit seen;
        keep_v = last_i_rdata;
        en0 = en_cnt;
        rdy_seen = 0;
        seen = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0070;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_en) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL flush_grant: got no access expected one at 0070");
        end
        @(posedge clk); #1;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.i_rdy) rdy_seen++;
        end
        checks++;
        if (bus.i_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall: got %b expected 1", bus.i_stall);
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.i_rdy) rdy_seen++;
        end
        checks++;
        if (rdy_seen !== 0) begin
            errors++;
            $display("FAIL flush_no_rdy: got %0d pulses expected 0", rdy_seen);
        end
        checks++;
        if (en_cnt - en0 !== LATENCY) begin
            errors++;
            $display("FAIL flush_mem_en_len: got %0d expected %0d", en_cnt - en0, LATENCY);
        end
        checks++;
        if (bus.i_rdata !== keep_v) begin
            errors++;
            $display("FAIL flush_rdata_kept: got %h expected %h", bus.i_rdata, keep_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hlt_and_idle_flush();
        int rq, rd, en0, ns;
        en0 = en_cnt;
        ns = start_addr_q.size();
        bus.hlt    = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0071;
        data_req(1'b0, 16'h0072, 16'h0000, rq, rd);
        repeat (3) @(negedge clk);
        checks++;
        if (en_cnt - en0 !== LATENCY || start_addr_q.size() !== ns + 1) begin
            errors++;
            $display("FAIL hlt_blocks_fetch: got %0d busy cycles expected %0d", en_cnt - en0, LATENCY);
        end
        @(posedge clk); #1;
        bus.hlt = 1'b0;
        fetch(16'h0071, rq, rd);
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0073;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_blocks: got mem_en=%b expected 0", bus.mem_en);
        end
        fetch(16'h0073, rq, rd);
    endtask

    task automatic test_reset_mid_access();
        logic [69:0] obs;
        int rq, rd;
        bit seen;
        seen = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0080;
        bus.d_wdata = 16'hBEEF;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_en) seen = 1'b1;
        end
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        #1;
        obs = {bus.i_rdy, bus.d_rdy, bus.i_stall, bus.d_stall, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata};
        checks++;
        if (!seen || obs !== 70'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h (access seen %b) expected 0", obs, seen);
        end
        last_i_rdata = 16'h0000;
        last_d_rdata = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        data_req(1'b0, 16'h0090, 16'h0000, rq, rd);
        checks++;
        if (rd - rq !== LATENCY + 1) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d expected %0d", rd - rq, LATENCY + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
        rst         = 1'b1;
        init_mem    = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.i_flush = 1'b0;
        bus.hlt     = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0000;
        bus.d_wdata = 16'h0000;
        test_reset();
        test_instr_fetch();
        test_data_write_read();
        test_simultaneous();
        test_burst_fairness();
        test_flush();
        test_hlt_and_idle_flush();
        test_reset_mid_access();
        checks++;
        if (exp_i_q.size() !== 0 || exp_d_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", exp_i_q.size(), exp_d_q.size());
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL mem_bus_stable: got %0d changes expected 0", unstable);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
